// File: rtl/vmem_line_sequencer.sv
// Vector cache access sequencer: turns one vector load/store into one or two
// line reads, a single-cycle data-op window, and optional line write-backs.
module vmem_line_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned BLOCK_W = 256,
    parameter int unsigned SIZE_W  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic                         req_store_i,
    input  logic [SIZE_W-1:0]            req_size_i,
    input  logic [DATA_W-1:0]            req_data_i,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic                         mem_req_we_o,
    output logic [ADDR_W-1:0]            mem_req_addr_o,
    output logic [BLOCK_W-1:0]           mem_req_wdata_o,
    input  logic                         mem_resp_valid_i,
    input  logic [BLOCK_W-1:0]           mem_resp_rdata_i,
    output logic                         win_valid_o,
    output logic [2*BLOCK_W-1:0]         win_block_o,
    output logic [$clog2(BLOCK_W/8)-1:0] win_offset_o,
    output logic [SIZE_W-1:0]            win_size_o,
    output logic                         win_cross_o,
    output logic                         win_store_o,
    output logic [DATA_W-1:0]            win_data_o,
    input  logic [2*BLOCK_W-1:0]         win_merged_i,
    input  logic [DATA_W-1:0]            win_load_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [DATA_W-1:0]            resp_data_o
);

    localparam int unsigned BYTES = BLOCK_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned SUM_W = OFF_W + 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_LO,
        S_WT_LO,
        S_RD_HI,
        S_WT_HI,
        S_OP,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t               state_q;
    logic                 ready_q;
    logic [ADDR_W-1:0]    base_q;
    logic                 cross_q;
    logic                 store_q;
    logic [BLOCK_W-1:0]   lo_q;
    logic [BLOCK_W-1:0]   hi_q;
    logic [BLOCK_W-1:0]   merged_hi_q;
    logic                 mem_valid_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [BLOCK_W-1:0]   mem_wdata_q;
    logic                 win_valid_q;
    logic [OFF_W-1:0]     win_offset_q;
    logic [SIZE_W-1:0]    win_size_q;
    logic [DATA_W-1:0]    win_data_q;
    logic                 resp_valid_q;
    logic [DATA_W-1:0]    resp_data_q;

    // Request decode: clamped size, line base, and whether the access spills into the next line
    logic [SIZE_W-1:0]    size_d;
    logic [OFF_W-1:0]     off_d;
    logic [ADDR_W-1:0]    base_d;
    logic                 cross_d;
    logic [ADDR_W-1:0]    hi_addr;

    always_comb begin
        size_d  = (req_size_i > SIZE_W'(BYTES)) ? SIZE_W'(BYTES) : req_size_i;
        off_d   = req_addr_i[OFF_W-1:0];
        base_d  = {req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
        cross_d = (SUM_W'(off_d) + SUM_W'(size_d)) > SUM_W'(BYTES);
        hi_addr = base_q + ADDR_W'(BYTES);
    end

    // Sequencer: state and every output are registered together, so outputs change only on state entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            base_q       <= '0;
            cross_q      <= 1'b0;
            store_q      <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
            merged_hi_q  <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            win_valid_q  <= 1'b0;
            win_offset_q <= '0;
            win_size_q   <= '0;
            win_data_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        ready_q      <= 1'b0;
                        base_q       <= base_d;
                        cross_q      <= cross_d;
                        store_q      <= req_store_i;
                        win_offset_q <= off_d;
                        win_size_q   <= size_d;
                        win_data_q   <= req_data_i;
                        lo_q         <= '0;
                        hi_q         <= '0;
                        merged_hi_q  <= '0;
                        if (size_d == '0) begin
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= '0;
                        end else begin
                            state_q     <= S_RD_LO;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= base_d;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                S_RD_LO: begin
                    if (mem_req_ready_i) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= S_WT_LO;
                    end
                end
                S_WT_LO: begin
                    if (mem_resp_valid_i) begin
                        lo_q <= mem_resp_rdata_i;
                        if (cross_q) begin
                            state_q     <= S_RD_HI;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= hi_addr;
                        end else begin
                            state_q     <= S_OP;
                            win_valid_q <= 1'b1;
                        end
                    end
                end
                S_RD_HI: begin
                    if (mem_req_ready_i) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= S_WT_HI;
                    end
                end
                S_WT_HI: begin
                    if (mem_resp_valid_i) begin
                        hi_q        <= mem_resp_rdata_i;
                        state_q     <= S_OP;
                        win_valid_q <= 1'b1;
                    end
                end
                S_OP: begin
                    win_valid_q <= 1'b0;
                    merged_hi_q <= win_merged_i[2*BLOCK_W-1:BLOCK_W];
                    if (store_q) begin
                        state_q     <= S_WR_LO;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= base_q;
                        mem_wdata_q <= win_merged_i[BLOCK_W-1:0];
                    end else begin
                        state_q      <= S_DONE;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= win_load_i;
                    end
                end
                S_WR_LO: begin
                    if (mem_req_ready_i) begin
                        if (cross_q) begin
                            state_q     <= S_WR_HI;
                            mem_addr_q  <= hi_addr;
                            mem_wdata_q <= merged_hi_q;
                        end else begin
                            state_q      <= S_DONE;
                            mem_valid_q  <= 1'b0;
                            mem_we_q     <= 1'b0;
                            mem_wdata_q  <= '0;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= '0;
                        end
                    end
                end
                S_WR_HI: begin
                    if (mem_req_ready_i) begin
                        state_q      <= S_DONE;
                        mem_valid_q  <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_wdata_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= '0;
                    end
                end
                S_DONE: begin
                    if (resp_ready_i) begin
                        state_q      <= S_IDLE;
                        ready_q      <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_data_q  <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o     = ready_q;
    assign mem_req_valid_o = mem_valid_q;
    assign mem_req_we_o    = mem_we_q;
    assign mem_req_addr_o  = mem_addr_q;
    assign mem_req_wdata_o = mem_wdata_q;
    assign win_valid_o     = win_valid_q;
    assign win_block_o     = {hi_q, lo_q};
    assign win_offset_o    = win_offset_q;
    assign win_size_o      = win_size_q;
    assign win_cross_o     = cross_q;
    assign win_store_o     = store_q;
    assign win_data_o      = win_data_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_data_o     = resp_data_q;

endmodule

// File: tb/tb_vmem_line_sequencer.sv
// Directed bench for vmem_line_sequencer: line-pattern memory, a byte-wise
// data-op model, and hand-computed expected lines, addresses and latencies.
module tb_vmem_line_sequencer;

    logic           clk;
    logic           rst;
    logic           req_valid_i;
    logic           req_ready_o;
    logic [31:0]    req_addr_i;
    logic           req_store_i;
    logic [5:0]     req_size_i;
    logic [255:0]   req_data_i;
    logic           mem_req_valid_o;
    logic           mem_req_ready_i;
    logic           mem_req_we_o;
    logic [31:0]    mem_req_addr_o;
    logic [255:0]   mem_req_wdata_o;
    logic           mem_resp_valid_i;
    logic [255:0]   mem_resp_rdata_i;
    logic           win_valid_o;
    logic [511:0]   win_block_o;
    logic [4:0]     win_offset_o;
    logic [5:0]     win_size_o;
    logic           win_cross_o;
    logic           win_store_o;
    logic [255:0]   win_data_o;
    logic [511:0]   win_merged_i;
    logic [255:0]   win_load_i;
    logic           resp_valid_o;
    logic           resp_ready_i;
    logic [255:0]   resp_data_o;

    vmem_line_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_store_i      (req_store_i),
        .req_size_i       (req_size_i),
        .req_data_i       (req_data_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_rdata_i (mem_resp_rdata_i),
        .win_valid_o      (win_valid_o),
        .win_block_o      (win_block_o),
        .win_offset_o     (win_offset_o),
        .win_size_o       (win_size_o),
        .win_cross_o      (win_cross_o),
        .win_store_o      (win_store_o),
        .win_data_o       (win_data_o),
        .win_merged_i     (win_merged_i),
        .win_load_i       (win_load_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_data_o      (resp_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    logic [31:0]  rd_log[$];
    logic [31:0]  wr_addr[$];
    logic [255:0] wr_data[$];
    int           win_cnt;
    logic         any_mem_valid;
    logic [4:0]   w_off;
    logic         w_cross;
    logic [5:0]   w_size;
    logic [255:0] w_hi;
    logic [255:0] w_load;

    // Memory line content: byte i of the line at A is A[7:0] + i
    function automatic logic [255:0] line_pat(input logic [31:0] a);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = 8'(a[7:0] + 8'(i));
        return r;
    endfunction

    function automatic logic [255:0] dop_extract(input logic [511:0] blk, input logic [4:0] off,
                                                 input logic [5:0] sz);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 32; j++)
            if (j < int'(sz)) r[8*j +: 8] = blk[8*(int'(off) + j) +: 8];
        return r;
    endfunction

    function automatic logic [511:0] dop_merge(input logic [511:0] blk, input logic [4:0] off,
                                               input logic [5:0] sz, input logic [255:0] d);
        logic [511:0] r;
        r = blk;
        for (int j = 0; j < 32; j++)
            if (j < int'(sz)) r[8*(int'(off) + j) +: 8] = d[8*j +: 8];
        return r;
    endfunction

    always_comb begin
        win_load_i   = dop_extract(win_block_o, win_offset_o, win_size_o);
        win_merged_i = dop_merge(win_block_o, win_offset_o, win_size_o, win_data_o);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wa_at(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [255:0] wd_at(input int i);
        return (i < wr_data.size()) ? wr_data[i] : {256{1'b1}};
    endfunction

    // One clock: log handshakes seen before the edge, then answer reads one cycle later
    task automatic step();
        logic        rd_hs;
        logic [31:0] a;
        rd_hs = mem_req_valid_o && mem_req_ready_i && !mem_req_we_o && !rst;
        a     = mem_req_addr_o;
        if (mem_req_valid_o) any_mem_valid = 1'b1;
        if (mem_req_valid_o && mem_req_ready_i && !rst) begin
            if (mem_req_we_o) begin
                wr_addr.push_back(mem_req_addr_o);
                wr_data.push_back(mem_req_wdata_o);
            end else begin
                rd_log.push_back(mem_req_addr_o);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_resp_valid_i = rd_hs;
        mem_resp_rdata_i = rd_hs ? line_pat(a) : '0;
        if (win_valid_o) begin
            win_cnt++;
            w_off   = win_offset_o;
            w_cross = win_cross_o;
            w_size  = win_size_o;
            w_hi    = win_block_o[511:256];
            w_load  = win_load_i;
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_addr.delete();
        wr_data.delete();
        win_cnt       = 0;
        any_mem_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic st, input logic [5:0] sz,
                         input logic [255:0] d, output int t);
        check("req_ready_idle", 256'(req_ready_o), 256'd1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_store_i = st;
        req_size_i  = sz;
        req_data_i  = d;
        t = cyc;
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_resp(input int t, output int lat);
        int n;
        n = 0;
        while (!resp_valid_o && n < 40) begin
            step();
            n++;
        end
        lat = cyc - t;
        check("resp_seen", 256'(resp_valid_o), 256'd1);
    endtask

    initial begin
        int t;
        int lat;
        rst              = 1'b1;
        req_valid_i      = 1'b0;
        req_addr_i       = '0;
        req_store_i      = 1'b0;
        req_size_i       = '0;
        req_data_i       = '0;
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b0;
        mem_resp_rdata_i = '0;
        resp_ready_i     = 1'b1;
        clear_logs();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_ready", 256'(req_ready_o), 256'd1);
        check("rst_outs_zero", 256'(|{mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
                                     win_valid_o, win_block_o, win_offset_o, win_size_o, win_cross_o,
                                     win_store_o, win_data_o, resp_valid_o, resp_data_o}), 256'd0);

        // Aligned load 0x100 size 32
        clear_logs();
        issue(32'h100, 1'b0, 6'd32, '0, t);
        wait_resp(t, lat);
        check("al_latency", 256'(lat), 256'd4);
        check("al_nreads", 256'(rd_log.size()), 256'd1);
        check("al_rd0", 256'(rd_at(0)), 256'h100);
        check("al_win_cnt", 256'(win_cnt), 256'd1);
        check("al_off", 256'(w_off), 256'd0);
        check("al_cross", 256'(w_cross), 256'd0);
        check("al_hi_zero", w_hi, 256'd0);
        check("al_data", resp_data_o,
              256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
        check("al_nwrites", 256'(wr_addr.size()), 256'd0);
        step();

        // Crossing load 0x11C size 8, response held off for 5 cycles
        clear_logs();
        resp_ready_i = 1'b0;
        issue(32'h11C, 1'b0, 6'd8, '0, t);
        wait_resp(t, lat);
        check("xl_latency", 256'(lat), 256'd6);
        check("xl_nreads", 256'(rd_log.size()), 256'd2);
        check("xl_rd0", 256'(rd_at(0)), 256'h100);
        check("xl_rd1", 256'(rd_at(1)), 256'h120);
        check("xl_off", 256'(w_off), 256'h1c);
        check("xl_cross", 256'(w_cross), 256'd1);
        check("xl_data", resp_data_o, 256'h232221201f1e1d1c);
        check("xl_data_vs_op", resp_data_o, w_load);
        for (int i = 0; i < 5; i++) begin
            step();
            check("xl_hold_valid", 256'(resp_valid_o), 256'd1);
            check("xl_hold_data", resp_data_o, 256'h232221201f1e1d1c);
        end
        resp_ready_i = 1'b1;
        step();
        check("xl_released", 256'(resp_valid_o), 256'd0);
        check("xl_nwrites", 256'(wr_addr.size()), 256'd0);

        // Non-crossing store 0x204 size 4
        clear_logs();
        issue(32'h204, 1'b1, 6'd4, 256'hdeadbeef, t);
        wait_resp(t, lat);
        check("ns_latency", 256'(lat), 256'd5);
        check("ns_nreads", 256'(rd_log.size()), 256'd1);
        check("ns_rd0", 256'(rd_at(0)), 256'h200);
        check("ns_nwrites", 256'(wr_addr.size()), 256'd1);
        check("ns_wa0", 256'(wa_at(0)), 256'h200);
        check("ns_wd0", wd_at(0),
              256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a0908deadbeef03020100);
        check("ns_resp_zero", resp_data_o, 256'd0);
        step();

        // Crossing store 0x3F0 size 32
        clear_logs();
        issue(32'h3F0, 1'b1, 6'd32,
              256'h5f5e5d5c5b5a595857565554535251504f4e4d4c4b4a49484746454443424140, t);
        wait_resp(t, lat);
        check("xs_latency", 256'(lat), 256'd8);
        check("xs_rd0", 256'(rd_at(0)), 256'h3e0);
        check("xs_rd1", 256'(rd_at(1)), 256'h400);
        check("xs_nwrites", 256'(wr_addr.size()), 256'd2);
        check("xs_wa0", 256'(wa_at(0)), 256'h3e0);
        check("xs_wd0", wd_at(0),
              256'h4f4e4d4c4b4a49484746454443424140efeeedecebeae9e8e7e6e5e4e3e2e1e0);
        check("xs_wa1", 256'(wa_at(1)), 256'h400);
        check("xs_wd1", wd_at(1),
              256'h1f1e1d1c1b1a191817161514131211105f5e5d5c5b5a59585756555453525150);
        step();

        // Memory backpressure in RD_LO and WR_LO, spurious read response during OP
        clear_logs();
        mem_req_ready_i = 1'b0;
        issue(32'h208, 1'b1, 6'd4, 256'h11223344, t);
        for (int i = 0; i < 3; i++) begin
            check("bp_rd_valid", 256'(mem_req_valid_o), 256'd1);
            check("bp_rd_addr", 256'(mem_req_addr_o), 256'h200);
            step();
        end
        check("bp_rd_valid_end", 256'(mem_req_valid_o), 256'd1);
        mem_req_ready_i = 1'b1;
        step();
        step();
        check("bp_op_window", 256'(win_valid_o), 256'd1);
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = {256{1'b1}};
        step();
        for (int i = 0; i < 3; i++) begin
            check("bp_wr_valid", 256'({mem_req_valid_o, mem_req_we_o}), 256'd3);
            check("bp_wr_addr", 256'(mem_req_addr_o), 256'h200);
            check("bp_wr_data", mem_req_wdata_o,
                  256'h1f1e1d1c1b1a191817161514131211100f0e0d0c112233440706050403020100);
            step();
        end
        mem_req_ready_i = 1'b1;
        step();
        check("bp_done", 256'(resp_valid_o), 256'd1);
        check("bp_nwrites", 256'(wr_addr.size()), 256'd1);
        check("bp_nreads", 256'(rd_log.size()), 256'd1);
        step();

        // Exact line fit (28 + 4 == 32) stays in one line
        clear_logs();
        issue(32'h11C, 1'b0, 6'd4, '0, t);
        wait_resp(t, lat);
        check("fit_latency", 256'(lat), 256'd4);
        check("fit_cross", 256'(w_cross), 256'd0);
        check("fit_nreads", 256'(rd_log.size()), 256'd1);
        check("fit_data", resp_data_o, 256'h1f1e1d1c);
        step();

        // Oversize request is clamped to a full line
        clear_logs();
        issue(32'h104, 1'b0, 6'd63, '0, t);
        wait_resp(t, lat);
        check("clamp_size", 256'(w_size), 256'd32);
        check("clamp_cross", 256'(w_cross), 256'd1);
        check("clamp_latency", 256'(lat), 256'd6);
        check("clamp_data", resp_data_o,
              256'h232221201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504);
        step();

        // Reset while waiting for the hi line
        clear_logs();
        issue(32'h11C, 1'b0, 6'd8, '0, t);
        step();
        step();
        step();
        check("rw_nreads", 256'(rd_log.size()), 256'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rw_ready", 256'(req_ready_o), 256'd1);
        check("rw_outs_zero", 256'(|{mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
                                    win_valid_o, win_block_o, win_offset_o, win_size_o, win_cross_o,
                                    win_store_o, win_data_o, resp_valid_o, resp_data_o}), 256'd0);
        step();
        check("rw_idle_after", 256'({req_ready_o, win_valid_o, resp_valid_o}), 256'd4);

        // Size-zero store completes without memory traffic
        clear_logs();
        issue(32'h500, 1'b1, 6'd0, {256{1'b1}}, t);
        wait_resp(t, lat);
        check("z_latency", 256'(lat), 256'd1);
        check("z_data", resp_data_o, 256'd0);
        check("z_no_mem", 256'(any_mem_valid), 256'd0);
        check("z_no_window", 256'(win_cnt), 256'd0);
        step();
        check("z_back_idle", 256'(req_ready_o), 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
